// File: rtl/execute_sequencer_if.sv
// Bundle of every signal between the execute sequencer and its neighbours:
// decode handshake, execute-stage operands/results, and the writeback pulses
// toward the register file, data memory and PC.
interface execute_sequencer_if;
    // decode side
    logic        instr_valid;
    logic        instr_ready;
    logic [4:0]  opcode;
    logic        am;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [3:0]  mem_addr;
    logic [4:0]  instr_mem_addr;
    logic [2:0]  s_r_amount;

    // execute stage side
    logic        ex_enable;
    logic [4:0]  ex_opcode;
    logic        ex_am;
    logic [2:0]  ex_rd;
    logic [2:0]  ex_rs1;
    logic [2:0]  ex_rs2;
    logic [3:0]  ex_mem_addr;
    logic [2:0]  ex_s_r_amount;
    logic [15:0] ex_result;
    logic        ex_zero;
    logic        ex_carry;
    logic        ex_ac;
    logic        ex_parity;

    // writeback side
    logic        reg_we;
    logic [2:0]  reg_waddr;
    logic [7:0]  reg_wdata;
    logic        mem_we;
    logic [3:0]  mem_waddr;
    logic [7:0]  mem_wdata;
    logic        pc_load;
    logic [4:0]  pc_target;

    // architectural status
    logic        zero_flag;
    logic        carry_flag;
    logic        ac_flag;
    logic        parity_flag;
    logic        cmp_flag;
    logic        busy;
    logic        halted;

    // Environment view: decode, execute stage and writeback consumers.
    modport master (
        output instr_valid, opcode, am, rd, rs1, rs2, mem_addr, instr_mem_addr, s_r_amount,
        output ex_result, ex_zero, ex_carry, ex_ac, ex_parity,
        input  instr_ready, ex_enable, ex_opcode, ex_am, ex_rd, ex_rs1, ex_rs2,
        input  ex_mem_addr, ex_s_r_amount,
        input  reg_we, reg_waddr, reg_wdata, mem_we, mem_waddr, mem_wdata,
        input  pc_load, pc_target,
        input  zero_flag, carry_flag, ac_flag, parity_flag, cmp_flag, busy, halted
    );

    // Sequencer view.
    modport slave (
        input  instr_valid, opcode, am, rd, rs1, rs2, mem_addr, instr_mem_addr, s_r_amount,
        input  ex_result, ex_zero, ex_carry, ex_ac, ex_parity,
        output instr_ready, ex_enable, ex_opcode, ex_am, ex_rd, ex_rs1, ex_rs2,
        output ex_mem_addr, ex_s_r_amount,
        output reg_we, reg_waddr, reg_wdata, mem_we, mem_waddr, mem_wdata,
        output pc_load, pc_target,
        output zero_flag, carry_flag, ac_flag, parity_flag, cmp_flag, busy, halted
    );
endinterface

// File: rtl/execute_sequencer.sv
// Multi-cycle controller in front of the 8-bit execute stage. Accepts one
// decoded instruction, holds it on the execute inputs for an op-dependent
// number of cycles, captures result and flags, then issues single-cycle
// register / memory / PC writeback pulses.
module execute_sequencer #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input logic              clk,
    input logic              reset,
    execute_sequencer_if.slave bus
);

    localparam logic [4:0] OP_MUL   = 5'b00011;
    localparam logic [4:0] OP_DIV   = 5'b00100;
    localparam logic [4:0] OP_STORE = 5'b01100;
    localparam logic [4:0] OP_JMP   = 5'b01101;
    localparam logic [4:0] OP_BZ    = 5'b01110;
    localparam logic [4:0] OP_BC    = 5'b10110;
    localparam logic [4:0] OP_BNZ   = 5'b10111;
    localparam logic [4:0] OP_BCMP  = 5'b11000;
    localparam logic [4:0] OP_CMP   = 5'b11001;
    localparam logic [4:0] OP_HALT  = 5'b11111;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_EXEC  = 3'd1,
        S_WB_LO = 3'd2,
        S_WB_HI = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t      state_reg, state_next;

    // latched instruction fields
    logic [4:0]  opcode_reg;
    logic        am_reg;
    logic [2:0]  rd_reg, rs1_reg, rs2_reg;
    logic [3:0]  mem_addr_reg;
    logic [4:0]  imaddr_reg;
    logic [2:0]  sra_reg;

    logic [7:0]  cnt_reg;
    logic [15:0] result_reg;
    logic        zero_reg, carry_reg, ac_reg, parity_reg, cmp_reg;

    // last-written values, shown on the data/address outputs between pulses
    logic [2:0]  reg_waddr_hold;
    logic [7:0]  reg_wdata_hold;
    logic [3:0]  mem_waddr_hold;
    logic [7:0]  mem_wdata_hold;
    logic [4:0]  pc_target_hold;

    // combinational FSM outputs
    logic        ready_c, ex_en_c;
    logic        reg_we_c, mem_we_c, pc_load_c;
    logic [2:0]  reg_waddr_c;
    logic [7:0]  reg_wdata_c;
    logic [3:0]  mem_waddr_c;
    logic [7:0]  mem_wdata_c;
    logic [4:0]  pc_target_c;

    logic        accept;
    logic        exec_last;

    function automatic logic is_shift(input logic [4:0] op);
        return (op >= 5'h10) && (op <= 5'h15);
    endfunction

    // ops that load zero/carry/ac/parity from the execute stage
    function automatic logic is_flag_op(input logic [4:0] op);
        return ((op != 5'h00) && (op <= 5'h0A)) || is_shift(op);
    endfunction

    // ops that write the low result byte back to the register file
    function automatic logic is_reg_op(input logic [4:0] op);
        return (op <= 5'h0B) || is_shift(op);
    endfunction

    // execute latency; shifts by zero still need one cycle
    function automatic logic [7:0] cycles_for(input logic [4:0] op, input logic [2:0] amt);
        logic [7:0] n;
        n = 8'd1;
        if (op == OP_MUL)
            n = 8'(MUL_CYCLES);
        else if (op == OP_DIV)
            n = 8'(DIV_CYCLES);
        else if (is_shift(op) && (amt != 3'd0))
            n = {5'd0, amt};
        return n;
    endfunction

    assign accept    = (state_reg == S_IDLE) && bus.instr_valid;
    assign exec_last = (state_reg == S_EXEC) && (cnt_reg == 8'd1);

    // state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state_reg <= S_IDLE;
        else
            state_reg <= state_next;
    end

    // latch instruction fields on accept and run the execute countdown
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            opcode_reg   <= '0;
            am_reg       <= 1'b0;
            rd_reg       <= '0;
            rs1_reg      <= '0;
            rs2_reg      <= '0;
            mem_addr_reg <= '0;
            imaddr_reg   <= '0;
            sra_reg      <= '0;
            cnt_reg      <= '0;
        end else if (accept) begin
            opcode_reg   <= bus.opcode;
            am_reg       <= bus.am;
            rd_reg       <= bus.rd;
            rs1_reg      <= bus.rs1;
            rs2_reg      <= bus.rs2;
            mem_addr_reg <= bus.mem_addr;
            imaddr_reg   <= bus.instr_mem_addr;
            sra_reg      <= bus.s_r_amount;
            cnt_reg      <= cycles_for(bus.opcode, bus.s_r_amount);
        end else if (state_reg == S_EXEC) begin
            cnt_reg      <= cnt_reg - 8'd1;
        end
    end

    // capture result and architectural flags on the final execute cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            result_reg <= '0;
            zero_reg   <= 1'b0;
            carry_reg  <= 1'b0;
            ac_reg     <= 1'b0;
            parity_reg <= 1'b0;
            cmp_reg    <= 1'b0;
        end else if (exec_last) begin
            result_reg <= bus.ex_result;
            if (is_flag_op(opcode_reg)) begin
                zero_reg   <= bus.ex_zero;
                carry_reg  <= bus.ex_carry;
                ac_reg     <= bus.ex_ac;
                parity_reg <= bus.ex_parity;
            end else if (opcode_reg == OP_CMP) begin
                cmp_reg    <= bus.ex_result[0];
            end
        end
    end

    // remember the address/data of each writeback so they stay stable between pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_waddr_hold <= '0;
            reg_wdata_hold <= '0;
            mem_waddr_hold <= '0;
            mem_wdata_hold <= '0;
            pc_target_hold <= '0;
        end else begin
            if (reg_we_c) begin
                reg_waddr_hold <= reg_waddr_c;
                reg_wdata_hold <= reg_wdata_c;
            end
            if (mem_we_c) begin
                mem_waddr_hold <= mem_waddr_c;
                mem_wdata_hold <= mem_wdata_c;
            end
            if (pc_load_c)
                pc_target_hold <= pc_target_c;
        end
    end

    // next-state and output decode
    always_comb begin
        state_next  = state_reg;
        ready_c     = 1'b0;
        ex_en_c     = 1'b0;
        reg_we_c    = 1'b0;
        reg_waddr_c = reg_waddr_hold;
        reg_wdata_c = reg_wdata_hold;
        mem_we_c    = 1'b0;
        mem_waddr_c = mem_waddr_hold;
        mem_wdata_c = mem_wdata_hold;
        pc_load_c   = 1'b0;
        pc_target_c = pc_target_hold;
        case (state_reg)
            S_IDLE: begin
                ready_c = 1'b1;
                if (bus.instr_valid)
                    state_next = (bus.opcode == OP_HALT) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                ex_en_c = 1'b1;
                if (cnt_reg == 8'd1)
                    state_next = S_WB_LO;
            end
            S_WB_LO: begin
                if (is_reg_op(opcode_reg)) begin
                    reg_we_c    = 1'b1;
                    reg_waddr_c = rd_reg;
                    reg_wdata_c = result_reg[7:0];
                end else if (opcode_reg == OP_STORE) begin
                    mem_we_c    = 1'b1;
                    mem_waddr_c = mem_addr_reg;
                    mem_wdata_c = result_reg[7:0];
                end else if ((opcode_reg == OP_JMP) ||
                             ((opcode_reg == OP_BZ)   && zero_reg)  ||
                             ((opcode_reg == OP_BC)   && carry_reg) ||
                             ((opcode_reg == OP_BNZ)  && !zero_reg) ||
                             ((opcode_reg == OP_BCMP) && cmp_reg)) begin
                    pc_load_c   = 1'b1;
                    pc_target_c = imaddr_reg;
                end
                if ((opcode_reg == OP_MUL) || (opcode_reg == OP_DIV))
                    state_next = S_WB_HI;
                else
                    state_next = S_IDLE;
            end
            S_WB_HI: begin
                reg_we_c    = 1'b1;
                reg_waddr_c = rd_reg + 3'd1;
                reg_wdata_c = result_reg[15:8];
                state_next  = S_IDLE;
            end
            S_HALT: begin
                state_next = S_HALT;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // ready is masked while reset is held so every output reads 0 during reset
    assign bus.instr_ready   = ready_c & reset;
    assign bus.ex_enable     = ex_en_c;
    assign bus.ex_opcode     = opcode_reg;
    assign bus.ex_am         = am_reg;
    assign bus.ex_rd         = rd_reg;
    assign bus.ex_rs1        = rs1_reg;
    assign bus.ex_rs2        = rs2_reg;
    assign bus.ex_mem_addr   = mem_addr_reg;
    assign bus.ex_s_r_amount = sra_reg;
    assign bus.reg_we        = reg_we_c;
    assign bus.reg_waddr     = reg_waddr_c;
    assign bus.reg_wdata     = reg_wdata_c;
    assign bus.mem_we        = mem_we_c;
    assign bus.mem_waddr     = mem_waddr_c;
    assign bus.mem_wdata     = mem_wdata_c;
    assign bus.pc_load       = pc_load_c;
    assign bus.pc_target     = pc_target_c;
    assign bus.zero_flag     = zero_reg;
    assign bus.carry_flag    = carry_reg;
    assign bus.ac_flag       = ac_reg;
    assign bus.parity_flag   = parity_reg;
    assign bus.cmp_flag      = cmp_reg;
    assign bus.busy          = (state_reg != S_IDLE);
    assign bus.halted        = (state_reg == S_HALT);

endmodule

// File: tb/tb_execute_sequencer.sv
// Directed testbench for execute_sequencer: one task per scenario, each with
// hand-computed expectations checked inline.
module tb_execute_sequencer;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    execute_sequencer_if bus();

    execute_sequencer #(.MUL_CYCLES(2), .DIV_CYCLES(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // advance to 1 time unit after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // present one instruction for a single accepting edge; returns in cycle T+1
    task automatic issue(input logic [4:0] op, input logic [2:0] rd, input logic [3:0] ma,
                         input logic [4:0] ima, input logic [2:0] sra,
                         input logic [15:0] res, input logic [3:0] flg);
        bus.opcode         = op;
        bus.am             = 1'b1;
        bus.rd             = rd;
        bus.rs1            = rd + 3'd1;
        bus.rs2            = rd + 3'd2;
        bus.mem_addr       = ma;
        bus.instr_mem_addr = ima;
        bus.s_r_amount     = sra;
        bus.ex_result      = res;
        {bus.ex_zero, bus.ex_carry, bus.ex_ac, bus.ex_parity} = flg;
        bus.instr_valid    = 1'b1;
        $display("issue op=%05b rd=%0d ma=%h target=%h sra=%0d res=%h", op, rd, ma, ima, sra, res);
        step();
        bus.instr_valid    = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_checks++; if (bus.instr_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b expected 0", bus.instr_ready); end
        n_checks++; if ({bus.busy, bus.halted, bus.ex_enable} !== 3'b000) begin n_fail++; $display("FAIL rst_status: got %b expected 000", {bus.busy, bus.halted, bus.ex_enable}); end
        n_checks++; if ({bus.reg_we, bus.mem_we, bus.pc_load} !== 3'b000) begin n_fail++; $display("FAIL rst_pulses: got %b expected 000", {bus.reg_we, bus.mem_we, bus.pc_load}); end
        n_checks++; if ({bus.zero_flag, bus.carry_flag, bus.ac_flag, bus.parity_flag, bus.cmp_flag} !== 5'b0) begin n_fail++; $display("FAIL rst_flags: got nonzero flags expected 00000"); end
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", bus.instr_ready); end
        $display("test_reset done");
    endtask

    task automatic test_add();
        issue(5'h01, 3'd2, 4'h0, 5'h00, 3'd0, 16'h0010, 4'b0010);
        n_checks++; if (bus.ex_enable !== 1'b1) begin n_fail++; $display("FAIL add_ex_enable: got %b expected 1", bus.ex_enable); end
        n_checks++; if ({bus.ex_opcode, bus.ex_rd, bus.ex_am, bus.ex_rs1, bus.ex_rs2} !== {5'h01, 3'd2, 1'b1, 3'd3, 3'd4}) begin n_fail++; $display("FAIL add_ex_fields: got %h/%0d/%b/%0d/%0d expected 01/2/1/3/4", bus.ex_opcode, bus.ex_rd, bus.ex_am, bus.ex_rs1, bus.ex_rs2); end
        n_checks++; if ({bus.instr_ready, bus.busy, bus.reg_we} !== 3'b010) begin n_fail++; $display("FAIL add_t1_status: got %b expected 010", {bus.instr_ready, bus.busy, bus.reg_we}); end
        step();
        n_checks++; if ({bus.reg_we, bus.reg_waddr, bus.reg_wdata} !== {1'b1, 3'd2, 8'h10}) begin n_fail++; $display("FAIL add_wb: got we=%b a=%0d d=%h expected 1/2/10", bus.reg_we, bus.reg_waddr, bus.reg_wdata); end
        n_checks++; if ({bus.ac_flag, bus.zero_flag, bus.ex_enable} !== 3'b100) begin n_fail++; $display("FAIL add_flags: got ac=%b z=%b en=%b expected 1/0/0", bus.ac_flag, bus.zero_flag, bus.ex_enable); end
        step();
        n_checks++; if ({bus.instr_ready, bus.busy, bus.reg_we} !== 3'b100) begin n_fail++; $display("FAIL add_t3_status: got %b expected 100", {bus.instr_ready, bus.busy, bus.reg_we}); end
        n_checks++; if ({bus.reg_waddr, bus.reg_wdata} !== {3'd2, 8'h10}) begin n_fail++; $display("FAIL add_hold: got a=%0d d=%h expected 2/10", bus.reg_waddr, bus.reg_wdata); end
        $display("test_add done");
    endtask

    task automatic test_back_to_back();
        bus.opcode = 5'h01; bus.rd = 3'd1; bus.ex_result = 16'h0021;
        {bus.ex_zero, bus.ex_carry, bus.ex_ac, bus.ex_parity} = 4'b0000;
        bus.instr_valid = 1'b1;
        step();                                  // T+1 EXEC
        step();                                  // T+2 WB_LO, result already captured
        n_checks++; if ({bus.reg_we, bus.reg_waddr, bus.reg_wdata} !== {1'b1, 3'd1, 8'h21}) begin n_fail++; $display("FAIL b2b_first_wb: got we=%b a=%0d d=%h expected 1/1/21", bus.reg_we, bus.reg_waddr, bus.reg_wdata); end
        bus.rd = 3'd5; bus.ex_result = 16'h0055;
        step();                                  // T+3 IDLE, second accepted at its end
        n_checks++; if ({bus.instr_ready, bus.reg_we} !== 2'b10) begin n_fail++; $display("FAIL b2b_ready: got %b expected 10", {bus.instr_ready, bus.reg_we}); end
        step();                                  // T+4 EXEC of second
        bus.instr_valid = 1'b0;
        n_checks++; if ({bus.ex_enable, bus.ex_rd} !== {1'b1, 3'd5}) begin n_fail++; $display("FAIL b2b_second_exec: got en=%b rd=%0d expected 1/5", bus.ex_enable, bus.ex_rd); end
        step();                                  // T+5 WB_LO of second
        n_checks++; if ({bus.reg_we, bus.reg_waddr, bus.reg_wdata} !== {1'b1, 3'd5, 8'h55}) begin n_fail++; $display("FAIL b2b_second_wb: got we=%b a=%0d d=%h expected 1/5/55", bus.reg_we, bus.reg_waddr, bus.reg_wdata); end
        step();
        $display("test_back_to_back done");
    endtask

    task automatic test_mul();
        issue(5'h03, 3'd7, 4'h0, 5'h00, 3'd0, 16'h1234, 4'b1001);
        n_checks++; if (bus.ex_enable !== 1'b1) begin n_fail++; $display("FAIL mul_exec1: got %b expected 1", bus.ex_enable); end
        step();
        n_checks++; if ({bus.ex_enable, bus.reg_we} !== 2'b10) begin n_fail++; $display("FAIL mul_exec2: got %b expected 10", {bus.ex_enable, bus.reg_we}); end
        step();
        n_checks++; if ({bus.reg_we, bus.reg_waddr, bus.reg_wdata, bus.ex_enable} !== {1'b1, 3'd7, 8'h34, 1'b0}) begin n_fail++; $display("FAIL mul_wb_lo: got we=%b a=%0d d=%h expected 1/7/34", bus.reg_we, bus.reg_waddr, bus.reg_wdata); end
        n_checks++; if ({bus.zero_flag, bus.carry_flag, bus.ac_flag, bus.parity_flag} !== 4'b1001) begin n_fail++; $display("FAIL mul_flags: got %b expected 1001", {bus.zero_flag, bus.carry_flag, bus.ac_flag, bus.parity_flag}); end
        step();
        n_checks++; if ({bus.reg_we, bus.reg_waddr, bus.reg_wdata, bus.instr_ready} !== {1'b1, 3'd0, 8'h12, 1'b0}) begin n_fail++; $display("FAIL mul_wb_hi: got we=%b a=%0d d=%h rdy=%b expected 1/0/12/0", bus.reg_we, bus.reg_waddr, bus.reg_wdata, bus.instr_ready); end
        step();
        n_checks++; if ({bus.instr_ready, bus.reg_we} !== 2'b10) begin n_fail++; $display("FAIL mul_ready: got %b expected 10", {bus.instr_ready, bus.reg_we}); end
        $display("test_mul done");
    endtask

    task automatic test_div();
        issue(5'h04, 3'd3, 4'h0, 5'h00, 3'd0, 16'h0205, 4'b0100);
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (bus.ex_enable !== 1'b1) begin n_fail++; $display("FAIL div_exec%0d: got %b expected 1", i, bus.ex_enable); end
            step();
        end
        n_checks++; if ({bus.reg_we, bus.reg_waddr, bus.reg_wdata, bus.carry_flag} !== {1'b1, 3'd3, 8'h05, 1'b1}) begin n_fail++; $display("FAIL div_wb_lo: got we=%b a=%0d d=%h c=%b expected 1/3/05/1", bus.reg_we, bus.reg_waddr, bus.reg_wdata, bus.carry_flag); end
        step();
        n_checks++; if ({bus.reg_we, bus.reg_waddr, bus.reg_wdata} !== {1'b1, 3'd4, 8'h02}) begin n_fail++; $display("FAIL div_wb_hi: got we=%b a=%0d d=%h expected 1/4/02", bus.reg_we, bus.reg_waddr, bus.reg_wdata); end
        step();
        n_checks++; if (bus.instr_ready !== 1'b1) begin n_fail++; $display("FAIL div_ready: got %b expected 1", bus.instr_ready); end
        $display("test_div done");
    endtask

    task automatic test_store();
        issue(5'h0C, 3'd0, 4'hA, 5'h00, 3'd0, 16'h00C3, 4'b0000);
        step();
        n_checks++; if ({bus.mem_we, bus.mem_waddr, bus.mem_wdata} !== {1'b1, 4'hA, 8'hC3}) begin n_fail++; $display("FAIL st_wb: got we=%b a=%h d=%h expected 1/a/c3", bus.mem_we, bus.mem_waddr, bus.mem_wdata); end
        n_checks++; if ({bus.reg_we, bus.pc_load, bus.carry_flag} !== 3'b001) begin n_fail++; $display("FAIL st_side: got %b expected 001", {bus.reg_we, bus.pc_load, bus.carry_flag}); end
        step();
        n_checks++; if ({bus.mem_we, bus.mem_waddr, bus.mem_wdata} !== {1'b0, 4'hA, 8'hC3}) begin n_fail++; $display("FAIL st_hold: got we=%b a=%h d=%h expected 0/a/c3", bus.mem_we, bus.mem_waddr, bus.mem_wdata); end
        $display("test_store done");
    endtask

    task automatic test_cmp_branch();
        issue(5'h19, 3'd0, 4'h0, 5'h00, 3'd0, 16'h0001, 4'b1111);
        step();
        n_checks++; if ({bus.cmp_flag, bus.reg_we, bus.carry_flag, bus.zero_flag} !== 4'b1010) begin n_fail++; $display("FAIL cmp1: got %b expected 1010", {bus.cmp_flag, bus.reg_we, bus.carry_flag, bus.zero_flag}); end
        step();
        issue(5'h18, 3'd0, 4'h0, 5'h15, 3'd0, 16'h0000, 4'b0000);
        step();
        n_checks++; if ({bus.pc_load, bus.pc_target} !== {1'b1, 5'h15}) begin n_fail++; $display("FAIL bcmp_taken: got ld=%b t=%h expected 1/15", bus.pc_load, bus.pc_target); end
        step();
        issue(5'h19, 3'd0, 4'h0, 5'h00, 3'd0, 16'h0000, 4'b0000);
        step();
        n_checks++; if (bus.cmp_flag !== 1'b0) begin n_fail++; $display("FAIL cmp0: got %b expected 0", bus.cmp_flag); end
        step();
        issue(5'h18, 3'd0, 4'h0, 5'h0A, 3'd0, 16'h0000, 4'b0000);
        step();
        n_checks++; if ({bus.pc_load, bus.pc_target} !== {1'b0, 5'h15}) begin n_fail++; $display("FAIL bcmp_not_taken: got ld=%b t=%h expected 0/15", bus.pc_load, bus.pc_target); end
        step();
        // zero=0, carry=1 held from DIV
        issue(5'h0E, 3'd0, 4'h0, 5'h03, 3'd0, 16'h0000, 4'b0000);
        step();
        n_checks++; if (bus.pc_load !== 1'b0) begin n_fail++; $display("FAIL bz_not_taken: got %b expected 0", bus.pc_load); end
        step();
        issue(5'h16, 3'd0, 4'h0, 5'h05, 3'd0, 16'h0000, 4'b0000);
        step();
        n_checks++; if ({bus.pc_load, bus.pc_target} !== {1'b1, 5'h05}) begin n_fail++; $display("FAIL bc_taken: got ld=%b t=%h expected 1/05", bus.pc_load, bus.pc_target); end
        step();
        issue(5'h17, 3'd0, 4'h0, 5'h06, 3'd0, 16'h0000, 4'b0000);
        step();
        n_checks++; if ({bus.pc_load, bus.pc_target} !== {1'b1, 5'h06}) begin n_fail++; $display("FAIL bnz_taken: got ld=%b t=%h expected 1/06", bus.pc_load, bus.pc_target); end
        step();
        issue(5'h0D, 3'd0, 4'h0, 5'h09, 3'd0, 16'h0000, 4'b0000);
        step();
        n_checks++; if ({bus.pc_load, bus.pc_target, bus.reg_we} !== {1'b1, 5'h09, 1'b0}) begin n_fail++; $display("FAIL jmp: got ld=%b t=%h we=%b expected 1/09/0", bus.pc_load, bus.pc_target, bus.reg_we); end
        step();
        $display("test_cmp_branch done");
    endtask

    task automatic test_shift();
        issue(5'h11, 3'd1, 4'h0, 5'h00, 3'd5, 16'h0081, 4'b0001);
        for (int i = 0; i < 5; i++) begin
            n_checks++; if ({bus.ex_enable, bus.ex_s_r_amount} !== {1'b1, 3'd5}) begin n_fail++; $display("FAIL shift5_exec%0d: got en=%b amt=%0d expected 1/5", i, bus.ex_enable, bus.ex_s_r_amount); end
            step();
        end
        n_checks++; if ({bus.reg_we, bus.reg_waddr, bus.reg_wdata, bus.parity_flag} !== {1'b1, 3'd1, 8'h81, 1'b1}) begin n_fail++; $display("FAIL shift5_wb: got we=%b a=%0d d=%h p=%b expected 1/1/81/1", bus.reg_we, bus.reg_waddr, bus.reg_wdata, bus.parity_flag); end
        step();
        issue(5'h11, 3'd2, 4'h0, 5'h00, 3'd0, 16'h0042, 4'b0000);
        n_checks++; if (bus.ex_enable !== 1'b1) begin n_fail++; $display("FAIL shift0_exec: got %b expected 1", bus.ex_enable); end
        step();
        n_checks++; if ({bus.reg_we, bus.reg_waddr, bus.reg_wdata} !== {1'b1, 3'd2, 8'h42}) begin n_fail++; $display("FAIL shift0_wb: got we=%b a=%0d d=%h expected 1/2/42", bus.reg_we, bus.reg_waddr, bus.reg_wdata); end
        step();
        $display("test_shift done");
    endtask

    task automatic test_reset_mid_div();
        issue(5'h04, 3'd6, 4'h0, 5'h00, 3'd0, 16'h0707, 4'b1111);
        step();
        step();                                  // third EXEC cycle
        n_checks++; if (bus.ex_enable !== 1'b1) begin n_fail++; $display("FAIL rmid_pre: got %b expected 1", bus.ex_enable); end
        #2;
        reset = 1'b0;
        #1;
        n_checks++; if ({bus.ex_enable, bus.busy, bus.instr_ready, bus.reg_we} !== 4'b0000) begin n_fail++; $display("FAIL rmid_status: got %b expected 0000", {bus.ex_enable, bus.busy, bus.instr_ready, bus.reg_we}); end
        n_checks++; if ({bus.ex_opcode, bus.ex_rd, bus.reg_waddr, bus.reg_wdata} !== 19'd0) begin n_fail++; $display("FAIL rmid_fields: got op=%h rd=%0d a=%0d d=%h expected all 0", bus.ex_opcode, bus.ex_rd, bus.reg_waddr, bus.reg_wdata); end
        n_checks++; if ({bus.mem_waddr, bus.pc_target, bus.zero_flag, bus.carry_flag, bus.ac_flag, bus.parity_flag, bus.cmp_flag} !== 14'd0) begin n_fail++; $display("FAIL rmid_misc: got nonzero mem/pc/flags expected 0"); end
        for (int i = 0; i < 5; i++) begin
            step();
            n_checks++; if ({bus.reg_we, bus.busy} !== 2'b00) begin n_fail++; $display("FAIL rmid_held%0d: got %b expected 00", i, {bus.reg_we, bus.busy}); end
        end
        reset = 1'b1;
        #1;
        n_checks++; if ({bus.instr_ready, bus.busy} !== 2'b10) begin n_fail++; $display("FAIL rmid_release: got %b expected 10", {bus.instr_ready, bus.busy}); end
        step();
        n_checks++; if ({bus.reg_we, bus.instr_ready} !== 2'b01) begin n_fail++; $display("FAIL rmid_idle: got %b expected 01", {bus.reg_we, bus.instr_ready}); end
        $display("test_reset_mid_div done");
    endtask

    task automatic test_halt();
        bus.opcode = 5'h1F;
        bus.instr_valid = 1'b1;
        step();
        bus.opcode = 5'h01;                      // decode keeps offering an ADD
        for (int i = 0; i < 20; i++) begin
            n_checks++; if ({bus.halted, bus.instr_ready, bus.busy} !== 3'b101) begin n_fail++; $display("FAIL halt_status%0d: got %b expected 101", i, {bus.halted, bus.instr_ready, bus.busy}); end
            n_checks++; if ({bus.reg_we, bus.mem_we, bus.pc_load, bus.ex_enable} !== 4'b0000) begin n_fail++; $display("FAIL halt_pulses%0d: got %b expected 0000", i, {bus.reg_we, bus.mem_we, bus.pc_load, bus.ex_enable}); end
            step();
        end
        bus.instr_valid = 1'b0;
        $display("test_halt done");
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.opcode = '0; bus.am = 1'b0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.mem_addr = '0; bus.instr_mem_addr = '0; bus.s_r_amount = '0;
        bus.ex_result = '0;
        {bus.ex_zero, bus.ex_carry, bus.ex_ac, bus.ex_parity} = 4'b0000;
        test_reset();
        test_add();
        test_back_to_back();
        test_mul();
        test_div();
        test_store();
        test_cmp_branch();
        test_shift();
        test_reset_mid_div();
        test_halt();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_sequencer.md
Name: execute_sequencer

Overview:
- Multi-cycle controller in front of the 8-bit execute stage.
- Accepts one decoded instruction at a time through a valid/ready handshake and drives the execute stage's operand and control inputs.
- Holds the instruction for the op-dependent latency, samples the result and flags, then issues one-cycle register-write, memory-write or PC-load pulses.
- Sits between the decode stage and the register file, memory bank and PC.

Parameters:
MUL_CYCLES, 2, execute cycles held for multiply (opcode 00011)
DIV_CYCLES, 4, execute cycles held for divide (opcode 00100)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
instr_valid  input  1  decode offers an instruction
instr_ready  output  1  sequencer can accept
opcode  input  5  decoded opcode
am  input  1  addressing mode
rd, rs1, rs2  input  3 each  register addresses
mem_addr  input  4  data memory address
instr_mem_addr  input  5  jump/branch target
s_r_amount  input  3  shift/rotate amount
ex_enable  output  1  enable to execute stage
ex_opcode, ex_am, ex_rd, ex_rs1, ex_rs2, ex_mem_addr, ex_s_r_amount  output  matching  latched fields to execute stage
ex_result  input  16  execute result
ex_zero, ex_carry, ex_ac, ex_parity  input  1 each  execute flags
reg_we  output  1  register write pulse
reg_waddr  output  3  write address
reg_wdata  output  8  write data
mem_we  output  1  memory write pulse
mem_waddr  output  4  memory write address
mem_wdata  output  8  memory write data
pc_load  output  1  PC load pulse
pc_target  output  5  PC load value
zero_flag, carry_flag, ac_flag, parity_flag, cmp_flag  output  1 each  architectural flags
busy  output  1  not IDLE
halted  output  1  in HALT

Behaviour:
- Reset: every output is 0, state IDLE, all latched fields 0. Reset is asynchronous and may assert in any state, including mid-DIV or mid-WB. No partial writeback or pulse may escape after reset asserts.
- States: IDLE, EXEC, WB_LO, WB_HI, HALT.
- IDLE:
  - instr_ready=1.
  - On instr_valid: latch all fields; load counter with N; go to EXEC.
  - Opcode 11111 goes to HALT instead.
- N by opcode:
  - 00011 -> MUL_CYCLES.
  - 00100 -> DIV_CYCLES.
  - 10000-10101 -> max(1, s_r_amount).
  - All other opcodes -> 1.
- EXEC:
  - ex_enable=1; ex_* hold the latched fields; counter decrements each cycle.
  - On the cycle the counter reads 1: capture ex_result into an internal 16-bit result register and go to WB_LO.
  - On that same cycle, update flags:
    - Opcodes 00001-01010 and 10000-10101 load zero/carry/ac/parity from ex_*.
    - 11001 loads cmp_flag from ex_result[0]; other flags are unchanged.
    - Other opcodes leave all flags unchanged.
- WB_LO (exactly one cycle; ex_enable=0):
  - 00000-01011 and 10000-10101: reg_we=1, reg_waddr=rd, reg_wdata=result[7:0].
  - 01100: mem_we=1, mem_waddr=mem_addr, mem_wdata=result[7:0].
  - 01101: pc_load=1, pc_target=instr_mem_addr.
  - 01110: pc_load = zero_flag.
  - 10110: pc_load = carry_flag.
  - 10111: pc_load = ~zero_flag.
  - 11000: pc_load = cmp_flag.
  - For all branches, the flag value is the one held at WB_LO.
  - 00011/00100 continue to WB_HI; every other opcode returns to IDLE.
  - Undefined opcodes (01111, 11010-11110) produce no pulses (NOP).
- WB_HI: reg_we=1, reg_waddr=(rd+1) mod 8, reg_wdata=result[15:8] (MUL high byte, DIV remainder); then IDLE.
- Pulses: reg_we, mem_we and pc_load are single-cycle. reg_waddr/reg_wdata, mem_waddr/mem_wdata and pc_target hold their last values when the corresponding pulse is low.
- Timing: accept at edge T; EXEC from T+1. A 1-cycle op pulses at T+2, and instr_ready=1 again at T+3. A back-to-back op can be accepted at T+3.
- HALT: instr_ready=0, halted=1, ex_enable=0, no pulses; instr_valid ignored. Left only by reset.
- busy=1 in every state except IDLE.
- instr_valid while not ready: the instruction is not consumed; decode must hold it.

Test Plan:
- ADD (00001) rd=2 with ex_result=0x0010, ex_ac=1 -> reg_we at T+2, reg_waddr=2, reg_wdata=0x10; ac_flag=1 and zero_flag=0 from T+2; instr_ready at T+3.
- MUL rd=7, ex_result=0x1234 -> EXEC for 2 cycles; WB_LO writes reg 7=0x34; next cycle writes reg 0=0x12 (wrap); instr_ready at T+5.
- DIV rd=3, ex_result=0x0205 -> ex_enable high 4 cycles; reg 3=0x05 then reg 4=0x02.
- Store 01100 mem_addr=0xA, ex_result=0x00C3 -> mem_we one cycle, mem_waddr=0xA, mem_wdata=0xC3, reg_we=0.
- Compare (ex_result[0]=1), then 11000 target=0x15 -> pc_load=1 with pc_target=0x15; repeat with ex_result[0]=0 -> pc_load stays 0.
- Shift 10001 s_r_amount=5 -> 5 EXEC cycles; s_r_amount=0 -> 1 cycle.
- Assert reset in the 3rd DIV EXEC cycle -> all outputs 0 immediately, no reg_we, IDLE after release.
- Opcode 11111 -> halted=1, instr_ready=0 for 20 cycles with instr_valid=1; no pulses.
